// File: rtl/simple_processor_pkg.sv
// ---------------------------------------------------------------------------
// simple_processor_pkg
//   Shared types and constants for the simple processor slice.
//   DATA_WIDTH   : datapath width
//   func_t       : memory-stage operation (LOAD / STORE; other codes illegal)
//   mem_size_t   : access size (byte / half / word; 2'b11 illegal)
//   lsu_state_t  : load/store unit FSM states
//   lsu_access_error() : accept-time legality check (func, size, alignment)
// ---------------------------------------------------------------------------
package simple_processor_pkg;

   localparam int unsigned DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      LOAD  = 2'b01,
      STORE = 2'b10
   } func_t;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } lsu_state_t;

   // Flags anything the memory port must never see: unknown function,
   // reserved size code, or an address not aligned to the access size.
   function automatic logic lsu_access_error(input func_t     func,
                                             input mem_size_t size,
                                             input logic [1:0] ea_lo);
      logic err;
      err = 1'b0;
      if ((func != LOAD) && (func != STORE)) begin
         err = 1'b1;
      end
      case (size)
         MEM_B:   ;
         MEM_H:   if (ea_lo[0])       err = 1'b1;
         MEM_W:   if (ea_lo != 2'b00) err = 1'b1;
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Combinational lane handling for the load/store unit.
//   size       : access size
//   offset     : ea[1:0], byte lane of the access
//   is_unsigned: 1 = zero-extend loads, 0 = sign-extend
//   store_data : raw store data (low bits significant)
//   mem_rdata  : raw word returned by memory
//   be         : byte enables for the addressed lanes
//   wdata      : store data replicated across lanes
//   load_data  : selected lane, extended to DATA_WIDTH
// ---------------------------------------------------------------------------
module lsu_align
   import simple_processor_pkg::*;
(
   input  mem_size_t                 size,
   input  logic [1:0]                offset,
   input  logic                      is_unsigned,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic [DATA_WIDTH/8-1:0]   be,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH-1:0]     load_data
);

   logic [DATA_WIDTH-1:0] lane;

   always_comb begin
      be    = '0;
      wdata = '0;
      case (size)
         MEM_B: begin
            be    = 4'b0001 << offset;
            wdata = {4{store_data[7:0]}};
         end
         MEM_H: begin
            be    = 4'b0011 << offset;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = '1;
            wdata = store_data;
         end
      endcase
   end

   // Shift the addressed byte down to lane 0 before extending.
   assign lane = mem_rdata >> {offset, 3'b000};

   always_comb begin
      load_data = '0;
      case (size)
         MEM_B:   load_data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, lane[7:0]}
                                          : {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
         MEM_H:   load_data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, lane[15:0]}
                                          : {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
         default: load_data = lane;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//   Sequential load/store unit: accepts one LOAD/STORE per valid/ready
//   handshake, computes ea = rs1 + imm, runs a req/gnt/rvalid memory
//   transaction and returns extended load data with an error flag.
//   Execute side : req_valid_i / req_ready_o, func_i, size_i, unsigned_i,
//                  rs1_data_i, imm_i, rs2_data_i
//   Response     : resp_valid_o (one-cycle pulse), rd_data_o, err_o
//   Memory side  : mem_req_o / mem_gnt_i, mem_we_o, mem_addr_o, mem_be_o,
//                  mem_wdata_o, mem_rvalid_i, mem_rdata_i
//   Errors: misalignment, reserved size, illegal func (on accept, no memory
//   access) and response timeout after TIMEOUT_CYCLES WAIT_RSP cycles.
// ---------------------------------------------------------------------------
module lsu_ctrl
   import simple_processor_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      clk_i,
   input  logic                      arst_ni,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  func_t                     func_i,
   input  mem_size_t                 size_i,
   input  logic                      unsigned_i,
   input  logic [DATA_WIDTH-1:0]     rs1_data_i,
   input  logic [DATA_WIDTH-1:0]     imm_i,
   input  logic [DATA_WIDTH-1:0]     rs2_data_i,
   output logic                      resp_valid_o,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      err_o,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic                      mem_we_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [DATA_WIDTH/8-1:0]   mem_be_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic                      mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t              state_q, state_d;
   func_t                   func_q;
   mem_size_t               size_q;
   logic                    uns_q;
   logic [ADDR_WIDTH-1:0]   ea_q;
   logic [DATA_WIDTH-1:0]   sdata_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    err_q;
   logic [CNT_WIDTH-1:0]    cnt_q;

   logic [DATA_WIDTH-1:0]   ea_sum;
   logic [ADDR_WIDTH-1:0]   ea_d;
   logic                    accept;
   logic                    acc_err;
   logic                    timeout_hit;

   logic [DATA_WIDTH/8-1:0] be_w;
   logic [DATA_WIDTH-1:0]   wdata_w;
   logic [DATA_WIDTH-1:0]   load_w;

   assign ea_sum      = rs1_data_i + imm_i;
   assign ea_d        = ea_sum[ADDR_WIDTH-1:0];
   assign accept      = (state_q == IDLE) && req_valid_i;
   assign acc_err     = lsu_access_error(func_i, size_i, ea_d[1:0]);
   // Fires in the last allowed WAIT_RSP cycle; rvalid in that cycle still wins.
   assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   // Lane logic works from the registered request so the memory port stays
   // stable while the execute stage moves on.
   lsu_align u_align (
      .size        (size_q),
      .offset      (ea_q[1:0]),
      .is_unsigned (uns_q),
      .store_data  (sdata_q),
      .mem_rdata   (mem_rdata_i),
      .be          (be_w),
      .wdata       (wdata_w),
      .load_data   (load_w)
   );

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_be_o     = '0;
      mem_wdata_o  = '0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_d = acc_err ? DONE : REQ;
            end
         end
         REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = (func_q == STORE);
            mem_addr_o  = {ea_q[ADDR_WIDTH-1:2], 2'b00};
            mem_be_o    = be_w;
            mem_wdata_o = wdata_w;
            if (mem_gnt_i) begin
               state_d = (func_q == STORE) ? DONE : WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (mem_rvalid_i || timeout_hit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            resp_valid_o = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture, timeout counter and held response.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         func_q    <= LOAD;
         size_q    <= MEM_B;
         uns_q     <= 1'b0;
         ea_q      <= '0;
         sdata_q   <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else if (accept) begin
         func_q    <= func_i;
         size_q    <= size_i;
         uns_q     <= unsigned_i;
         ea_q      <= ea_d;
         sdata_q   <= rs2_data_i;
         rd_data_q <= '0;
         err_q     <= acc_err;
         cnt_q     <= '0;
      end else if (state_q == WAIT_RSP) begin
         if (mem_rvalid_i) begin
            rd_data_q <= load_w;
         end else if (timeout_hit) begin
            err_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign rd_data_o = rd_data_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl: directed scenarios followed by random
//   transactions, each compared against a byte-level reference model.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
   import simple_processor_pkg::*;

   localparam int unsigned TO = 16;

   logic        clk_i = 1'b0;
   logic        arst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   func_t       func_i = LOAD;
   mem_size_t   size_i = MEM_B;
   logic        unsigned_i = 1'b0;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] imm_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic        resp_valid_o;
   logic [31:0] rd_data_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk_i),
      .arst_ni      (arst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .func_i       (func_i),
      .size_i       (size_i),
      .unsigned_i   (unsigned_i),
      .rs1_data_i   (rs1_data_i),
      .imm_i        (imm_i),
      .rs2_data_i   (rs2_data_i),
      .resp_valid_o (resp_valid_o),
      .rd_data_o    (rd_data_o),
      .err_o        (err_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // One transaction from accept to the idle cycle after the response.
   // gnt_dly: REQ stall cycles; rv_dly: WAIT_RSP cycles before rvalid
   // (>= TO means rvalid is withheld); late_rv: send a stray rvalid later.
   task automatic run_op(input logic [1:0] func, input logic [1:0] size, input logic uns,
                         input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                         input int unsigned gnt_dly, input int unsigned rv_dly,
                         input logic [31:0] rdata, input logic late_rv);
      logic [31:0] ea, exp_wd, exp_rd, exp_addr;
      logic [3:0]  exp_be;
      logic        exp_err, is_store, timed_out;
      int unsigned n, off, wait_cycles;
      longint      v, span;

      ea       = rs1 + imm;
      off      = 32'(ea[1:0]);
      n        = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      is_store = (func == 2'b10);
      exp_err  = !((func == 2'b01) || is_store) || (size == 2'b11) || ((ea % n) != 0);
      exp_addr = ea & ~32'h3;
      exp_be   = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = rs2[8*(i % n) +: 8];
      span = longint'(1) << (8 * n);
      v    = longint'(rdata >> (8 * off)) % span;
      if (!uns && (v >= span / 2)) v = v - span;
      exp_rd = 32'(v);

      check("ready_before", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      func_i      = func_t'(func);
      size_i      = mem_size_t'(size);
      unsigned_i  = uns;
      rs1_data_i  = rs1;
      imm_i       = imm;
      rs2_data_i  = rs2;
      tick;
      req_valid_i = 1'b0;
      func_i      = func_t'(2'($urandom));
      size_i      = mem_size_t'(2'($urandom));
      unsigned_i  = 1'($urandom);
      rs1_data_i  = $urandom;
      imm_i       = $urandom;
      rs2_data_i  = $urandom;

      timed_out = 1'b0;
      if (exp_err) begin
         check("err_resp_valid", 32'(resp_valid_o), 32'd1);
         check("err_flag", 32'(err_o), 32'd1);
         check("err_rd_zero", rd_data_o, 32'd0);
         check("err_no_req", 32'(mem_req_o), 32'd0);
      end else begin
         for (int unsigned k = 0; k <= gnt_dly; k++) begin
            check("req_high", 32'(mem_req_o), 32'd1);
            check("req_we", 32'(mem_we_o), 32'(is_store));
            check("req_addr", mem_addr_o, exp_addr);
            check("req_be", 32'(mem_be_o), 32'(exp_be));
            check("req_wdata", mem_wdata_o, exp_wd);
            check("req_no_resp", 32'(resp_valid_o), 32'd0);
            mem_gnt_i    = (k == gnt_dly);
            mem_rvalid_i = 1'($urandom);
            mem_rdata_i  = $urandom;
            tick;
         end
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (!is_store) begin
            timed_out   = (rv_dly >= TO);
            wait_cycles = timed_out ? TO : rv_dly + 1;
            for (int unsigned w = 0; w < wait_cycles; w++) begin
               check("wait_no_req", 32'(mem_req_o), 32'd0);
               check("wait_no_resp", 32'(resp_valid_o), 32'd0);
               if (!timed_out && (w == rv_dly)) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = rdata;
               end
               tick;
               mem_rvalid_i = 1'b0;
               mem_rdata_i  = $urandom;
            end
         end
         check("resp_valid", 32'(resp_valid_o), 32'd1);
         check("resp_err", 32'(err_o), 32'(timed_out));
         check("resp_rd", rd_data_o, (is_store || timed_out) ? 32'd0 : exp_rd);
         check("resp_no_req", 32'(mem_req_o), 32'd0);
      end
      if (is_store || exp_err || timed_out) exp_rd = '0;
      exp_err = exp_err || timed_out;

      tick;
      check("after_no_resp", 32'(resp_valid_o), 32'd0);
      check("after_ready", 32'(req_ready_o), 32'd1);
      check("hold_rd", rd_data_o, exp_rd);
      check("hold_err", 32'(err_o), 32'(exp_err));
      if (late_rv) begin
         tick;
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = $urandom;
         tick;
         mem_rvalid_i = 1'b0;
         check("late_no_resp", 32'(resp_valid_o), 32'd0);
         tick;
         check("late_no_resp2", 32'(resp_valid_o), 32'd0);
         check("late_hold_err", 32'(err_o), 32'd1);
      end
   endtask

   initial begin
      logic [1:0]  r_func, r_size;
      logic [31:0] r_rs1, r_ea;
      int unsigned r;

      // Reset state
      #12;
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_resp", 32'(resp_valid_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_rd", rd_data_o, 32'd0);
      check("rst_req", 32'(mem_req_o), 32'd0);
      check("rst_we", 32'(mem_we_o), 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_be", 32'(mem_be_o), 32'd0);
      check("rst_wdata", mem_wdata_o, 32'd0);
      #3 arst_ni = 1'b1;
      tick;

      // Directed scenarios
      run_op(2'b10, 2'd2, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, 0, 0, '0, 1'b0);
      run_op(2'b10, 2'd0, 1'b0, 32'h200, 32'h3, 32'h0000005A, 3, 0, '0, 1'b0);
      run_op(2'b01, 2'd1, 1'b0, 32'h300, 32'h2, 32'h0, 0, 0, 32'h8001_1234, 1'b0);
      run_op(2'b01, 2'd1, 1'b1, 32'h300, 32'h2, 32'h0, 0, 0, 32'h8001_1234, 1'b0);
      run_op(2'b01, 2'd2, 1'b0, 32'h400, 32'h1, 32'h0, 0, 0, '0, 1'b0);
      run_op(2'b01, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0, 0, TO, '0, 1'b1);
      run_op(2'b01, 2'd2, 1'b0, 32'h600, 32'h0, 32'h0, 1, TO - 1, 32'h1234_5678, 1'b0);
      run_op(2'b01, 2'd0, 1'b0, 32'h700, 32'h3, 32'h0, 0, 1, 32'h80FF_FFFF, 1'b0);
      run_op(2'b11, 2'd0, 1'b0, 32'h800, 32'h0, 32'h0, 0, 0, '0, 1'b0);
      run_op(2'b10, 2'd3, 1'b0, 32'h900, 32'h0, 32'h0, 0, 0, '0, 1'b0);

      // Async reset while a request is pending
      req_valid_i = 1'b1;
      func_i      = LOAD;
      size_i      = MEM_W;
      rs1_data_i  = 32'hA00;
      imm_i       = 32'h0;
      tick;
      req_valid_i = 1'b0;
      check("rst_mid_req_before", 32'(mem_req_o), 32'd1);
      arst_ni = 1'b0;
      #1;
      check("rst_mid_req_drop", 32'(mem_req_o), 32'd0);
      check("rst_mid_ready", 32'(req_ready_o), 32'd1);
      #3 arst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("rst_mid_no_resp", 32'(resp_valid_o), 32'd0);
         check("rst_mid_ready_after", 32'(req_ready_o), 32'd1);
         check("rst_mid_no_req", 32'(mem_req_o), 32'd0);
      end

      // Random transactions
      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 19);
         r_func = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : ((r % 2) != 0) ? 2'b01 : 2'b10;
         r = $urandom_range(0, 9);
         r_size = (r == 0) ? 2'b11 : 2'(r % 3);
         r_rs1 = $urandom;
         r_ea  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (r_size == 2'd1) r_ea[0] = 1'b0;
            if (r_size == 2'd2) r_ea[1:0] = 2'b00;
         end
         r = $urandom_range(0, 14);
         run_op(r_func, r_size, 1'($urandom), r_rs1, r_ea - r_rs1, $urandom,
                $urandom_range(0, 3),
                (r == 0) ? $urandom_range(TO, TO + 3) : (r == 1) ? TO - 1 : $urandom_range(0, 3),
                $urandom, 1'b0);
         r = $urandom_range(0, 2);
         for (int g = 0; g < int'(r); g++) begin
            tick;
            check("gap_no_resp", 32'(resp_valid_o), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Sequential load/store unit that supersedes the combinational memory-stage block. It accepts one LOAD/STORE per valid/ready handshake and computes the effective address rs1+imm. It drives a req/gnt/rvalid memory port with byte enables, and returns sign/zero-extended load data. Misalignment, illegal operations and response timeouts are reported through an error flag. It sits between the execute stage and the data memory/bus interface.

Parameters:
ADDR_WIDTH, 32, width of the memory address bus; effective address is truncated to this width.
TIMEOUT_CYCLES, 16, maximum WAIT_RSP cycles before a load is aborted with an error; must be >= 1.

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  execute stage presents an operation
req_ready_o  out  1  unit can accept; high only in IDLE
func_i  in  func_t  LOAD or STORE; any other value is illegal
size_i  in  mem_size_t  byte/half/word access size
unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
rs1_data_i  in  DATA_WIDTH  base address
imm_i  in  DATA_WIDTH  address offset
rs2_data_i  in  DATA_WIDTH  store data, in the low bits
resp_valid_o  out  1  one-cycle completion pulse
rd_data_o  out  DATA_WIDTH  load result; 0 for stores and errors
err_o  out  1  valid with resp_valid_o
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted the request
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_WIDTH  word-aligned address (low 2 bits = 0)
mem_be_o  out  DATA_WIDTH/8  byte enables
mem_wdata_o  out  DATA_WIDTH  lane-replicated store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT_RSP, DONE. Reset forces IDLE. At reset all outputs are 0 except req_ready_o, which is 1.
- IDLE: on req_valid_i, register func, size, unsigned, ea = rs1+imm (mod 2^ADDR_WIDTH), and store data.
- Error on accept: misaligned (H with ea[0]=1, W with ea[1:0]!=0), size 2'b11, or illegal func. Go directly to DONE with err_o=1; mem_req_o never asserts.
- Otherwise go to REQ.
- REQ: mem_req_o=1 with addr/we/be/wdata held stable until mem_gnt_i.
  - On gnt, a STORE goes to DONE and a LOAD goes to WAIT_RSP.
  - No timeout applies in REQ.
  - mem_rvalid_i is ignored in REQ.
- WAIT_RSP: mem_req_o=0.
  - On mem_rvalid_i, capture and align the data, then go to DONE.
  - A counter increments each cycle without rvalid. When it reaches TIMEOUT_CYCLES, go to DONE with err_o=1 and rd_data_o=0. A late rvalid after this is ignored.
- DONE: resp_valid_o=1 for exactly one cycle, then IDLE. rd_data_o and err_o are held until the next accept.
- Byte enables: B = 4'b0001<<ea[1:0]; H = 4'b0011<<ea[1:0]; W = 4'b1111.
- Store data: B replicates rs2[7:0] x4; H replicates rs2[15:0] x2; W uses rs2 as is.
- Load alignment: select the lane by ea[1:0], then extend per unsigned_i to DATA_WIDTH.
- Minimum latency (accept cycle = 0, gnt in first REQ cycle):
  - store: resp_valid_o at cycle 2;
  - load with rvalid the cycle after gnt: resp_valid_o at cycle 3;
  - error detected on accept: resp_valid_o at cycle 1.
- Async reset mid-transaction drops mem_req_o immediately and the operation is lost; no response is produced.

Decomposition:
- simple_processor_pkg gains mem_size_t (MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10) and lsu_state_t. It reuses DATA_WIDTH and func_t (LOAD, STORE).
- One combinational sub-module, lsu_align, handles be/wdata generation and load lane extraction with extension. The FSM and timeout counter stay in lsu_ctrl.

Test Plan:
- STORE W, rs1=0x100, imm=4, rs2=0xDEADBEEF, gnt immediate -> addr 0x104, be 4'b1111, wdata 0xDEADBEEF, resp_valid at cycle 2, err=0.
- STORE B, ea=0x203, rs2=0x5A, gnt after 3 stall cycles -> req/addr/be/wdata stable throughout, addr 0x200, be 4'b1000, wdata 0x5A5A5A5A.
- LOAD H signed, ea=0x302, rdata=0x8001_1234 -> rd_data_o=0xFFFF8001; repeat with unsigned -> 0x00008001.
- LOAD W, ea=0x401 -> err_o=1 at cycle 1, mem_req_o never 1, rd_data_o=0.
- LOAD W, rvalid withheld, TIMEOUT_CYCLES=16 -> err_o=1 after 16 WAIT_RSP cycles; an rvalid 2 cycles later causes no second resp_valid.
- Assert arst_ni low during REQ -> mem_req_o=0 immediately, req_ready_o=1 after release, no resp_valid_o.
